// File: rtl/datapath_booth.sv
`default_nettype none
// ============================================================================
// Module   : datapath_booth
// Purpose  : Datapath of a radix-2 Booth signed multiplier. Holds the
//            multiplicand M, the sign-extended accumulator A (WIDTH+1 bits),
//            the multiplier/low-product register Q and the Booth guard bit
//            q_1. An external control unit sequences it through the
//            load / add-or-subtract / arithmetic-shift steps.
// Ports    : clk, rst_n            - clock (rising edge), async active-low reset
//            Multiplicando          - signed multiplicand (WIDTH)
//            Multiplicador          - signed multiplier (WIDTH)
//            CargaA, DesplazaA,
//            ResetA, CargaQ,
//            DesplazaQ, CargaM,
//            Resta, Fin             - control strobes from the control unit
//            q0, q_1                - Q[0] and guard bit back to the control unit
//            Producto               - signed product (2*WIDTH)
//            Valido                 - product-valid indication
// Config   : RESULT_REG_EN - when defined, Producto is captured once per Fin
//            rising edge and Valido is a one-cycle registered pulse; when
//            undefined, Producto is the live {A,Q} value and Valido = Fin.
// Revision : 1.0 - initial release
// ============================================================================
module datapath_booth #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     Multiplicando,
    input  logic [WIDTH-1:0]     Multiplicador,
    input  logic                 CargaA,
    input  logic                 DesplazaA,
    input  logic                 ResetA,
    input  logic                 CargaQ,
    input  logic                 DesplazaQ,
    input  logic                 CargaM,
    input  logic                 Resta,
    input  logic                 Fin,
    output logic                 q0,
    output logic                 q_1,
    output logic [2*WIDTH-1:0]   Producto,
    output logic                 Valido
);

    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH:0]     a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH:0]     m_sext;
    logic [WIDTH:0]     a_sum;
    logic [2*WIDTH-1:0] raw_product;

    // The accumulator is one bit wider than the operands so that
    // subtracting M = -2^(WIDTH-1) cannot overflow.
    assign m_sext = {m_reg[WIDTH-1], m_reg};
    assign a_sum  = Resta ? (a_reg - m_sext) : (a_reg + m_sext);

    // The extra accumulator bit is only a guard; the product lives in the
    // low WIDTH bits of A followed by Q.
    assign raw_product = {a_reg[WIDTH-1:0], q_reg};

    assign q0 = q_reg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg <= '0;
            a_reg <= '0;
            q_reg <= '0;
            q_1   <= 1'b0;
        end else begin
            if (CargaM) begin
                m_reg <= Multiplicando;
            end

            if (ResetA) begin
                a_reg <= '0;
            end else if (CargaA) begin
                a_reg <= a_sum;
            end else if (DesplazaA) begin
                a_reg <= {a_reg[WIDTH], a_reg[WIDTH:1]};
            end

            // Q and q_1 shift from the pre-edge A[0] and Q[0], so a combined
            // DesplazaA/DesplazaQ is one arithmetic shift of {A,Q,q_1}.
            if (CargaQ) begin
                q_reg <= Multiplicador;
                q_1   <= 1'b0;
            end else if (DesplazaQ) begin
                q_reg <= {a_reg[0], q_reg[WIDTH-1:1]};
                q_1   <= q_reg[0];
            end
        end
    end

`ifdef RESULT_REG_EN
    logic fin_d;
    logic capture;

    assign capture = Fin && !fin_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_d    <= 1'b0;
            Producto <= '0;
            Valido   <= 1'b0;
        end else begin
            fin_d  <= Fin;
            Valido <= capture;
            if (capture) begin
                Producto <= raw_product;
            end
        end
    end
`else
    assign Producto = raw_product;
    assign Valido   = Fin;
`endif

endmodule
`default_nettype wire

// File: tb/tb_datapath_booth.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_booth
// Purpose  : Self-checking bench for datapath_booth. The bench plays the role
//            of the control unit, deriving each Booth step from the multiplier
//            bits it chose, and compares the DUT with signed products computed
//            by plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_booth;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [W-1:0]   mcand = '0;
    logic [W-1:0]   mplier = '0;
    logic           carga_a = 1'b0;
    logic           desplaza_a = 1'b0;
    logic           reset_a = 1'b0;
    logic           carga_q = 1'b0;
    logic           desplaza_q = 1'b0;
    logic           carga_m = 1'b0;
    logic           resta = 1'b0;
    logic           fin = 1'b0;
    logic           q0;
    logic           q_1;
    logic [2*W-1:0] producto;
    logic           valido;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef RESULT_REG_EN
    localparam logic VALID_WHILE_HELD = 1'b0;
`else
    localparam logic VALID_WHILE_HELD = 1'b1;
`endif

    datapath_booth #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Multiplicando (mcand),
        .Multiplicador (mplier),
        .CargaA        (carga_a),
        .DesplazaA     (desplaza_a),
        .ResetA        (reset_a),
        .CargaQ        (carga_q),
        .DesplazaQ     (desplaza_q),
        .CargaM        (carga_m),
        .Resta         (resta),
        .Fin           (fin),
        .q0            (q0),
        .q_1           (q_1),
        .Producto      (producto),
        .Valido        (valido)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got n_checks=%0d expected completion", n_checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    // Assert Fin, check the product and Valido, optionally keep Fin high.
    task automatic finish_check(input logic [2*W-1:0] exp, input int hold);
        fin = 1'b1;
        tick();
        n_checks++;
        if (producto !== exp) begin
            n_fail++;
            $display("FAIL product: got %h expected %h", producto, exp);
        end
        n_checks++;
        if (valido !== 1'b1) begin
            n_fail++;
            $display("FAIL valid_pulse: got %b expected 1", valido);
        end
        for (int k = 0; k < hold; k++) begin
            tick();
            n_checks++;
            if (valido !== VALID_WHILE_HELD || producto !== exp) begin
                n_fail++;
                $display("FAIL fin_hold[%0d]: got valido=%b producto=%h expected valido=%b producto=%h",
                         k, valido, producto, VALID_WHILE_HELD, exp);
            end
        end
        fin = 1'b0;
        tick();
        n_checks++;
        if (valido !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_drop: got %b expected 0", valido);
        end
    endtask

    // Full Booth sequence driven like the control unit would. If abort_iter
    // matches an iteration, reset is pulsed at that point instead.
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int abort_iter, input int hold);
        logic bi;
        logic bp;
        mcand   = a;
        mplier  = b;
        carga_m = 1'b1;
        carga_q = 1'b1;
        reset_a = 1'b1;
        tick();
        carga_m = 1'b0;
        carga_q = 1'b0;
        reset_a = 1'b0;
        // M must ignore the input once loaded.
        mcand   = W'($urandom);
        mplier  = W'($urandom);
        for (int i = 0; i < W; i++) begin
            bi = b[i];
            bp = (i == 0) ? 1'b0 : b[i-1];
            n_checks++;
            if (q0 !== bi || q_1 !== bp) begin
                n_fail++;
                $display("FAIL booth_bits[%0d]: got q0=%b q_1=%b expected q0=%b q_1=%b",
                         i, q0, q_1, bi, bp);
            end
            if (i == abort_iter) begin
                #2;
                rst_n = 1'b0;
                #1;
                n_checks++;
                if (q0 !== 1'b0 || q_1 !== 1'b0 || producto !== '0 || valido !== 1'b0) begin
                    n_fail++;
                    $display("FAIL async_reset: got q0=%b q_1=%b producto=%h valido=%b expected all 0",
                             q0, q_1, producto, valido);
                end
                tick();
                n_checks++;
                if (producto !== '0 || valido !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_held: got producto=%h valido=%b expected 0/0", producto, valido);
                end
                @(negedge clk);
                rst_n = 1'b1;
                tick();
                n_checks++;
                if (valido !== 1'b0) begin
                    n_fail++;
                    $display("FAIL no_valid_after_abort: got %b expected 0", valido);
                end
                return;
            end
            if (bi && !bp) begin
                carga_a = 1'b1;
                resta   = 1'b1;
                tick();
            end else if (!bi && bp) begin
                carga_a = 1'b1;
                resta   = 1'b0;
                tick();
            end
            carga_a    = 1'b0;
            desplaza_a = 1'b1;
            desplaza_q = 1'b1;
            resta      = 1'($urandom);  // irrelevant without CargaA
            tick();
            desplaza_a = 1'b0;
            desplaza_q = 1'b0;
            resta      = 1'b0;
        end
        finish_check(ref_product(a, b), hold);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (q0 !== 1'b0 || q_1 !== 1'b0 || producto !== '0 || valido !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got q0=%b q_1=%b producto=%h valido=%b expected all 0",
                     q0, q_1, producto, valido);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        run_mult(4'b0011, 4'b1110, -1, 0);   // 3 * -2  = FA
        run_mult(4'b0111, 4'b0111, -1, 0);   // 7 * 7   = 31
        run_mult(4'b1000, 4'b1000, -1, 0);   // -8 * -8 = 40
    endtask

    task automatic test_fin_hold();
        run_mult(4'b1000, 4'b0111, -1, 10);  // -8 * 7 = C8
    endtask

    task automatic test_midway_reset();
        run_mult(4'b1000, 4'b0111, 1, 0);
        run_mult(4'b0010, 4'b0011, -1, 0);   // 2 * 3 = 06
    endtask

    task automatic test_priority();
        logic [W-1:0] b;
        b          = W'($urandom) | 4'b0001;
        mplier     = b;
        reset_a    = 1'b1;
        carga_a    = 1'b1;
        resta      = 1'b1;
        desplaza_a = 1'b1;
        carga_q    = 1'b1;
        desplaza_q = 1'b1;
        tick();
        reset_a    = 1'b0;
        carga_a    = 1'b0;
        resta      = 1'b0;
        desplaza_a = 1'b0;
        carga_q    = 1'b0;
        desplaza_q = 1'b0;
        n_checks++;
        if (q0 !== b[0] || q_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL priority_q: got q0=%b q_1=%b expected q0=%b q_1=0", q0, q_1, b[0]);
        end
        finish_check({{W{1'b0}}, b}, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            run_mult(W'($urandom), W'($urandom), -1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_fin_hold();
        test_midway_reset();
        test_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/datapath_booth.md
DATAPATH_BOOTH -- requirements
Module: datapath_booth

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width in bits; 4 matches the four-iteration control unit.
REQ-002 SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port Multiplicando, input, WIDTH bits: signed multiplicand.
REQ-006 SHALL have port Multiplicador, input, WIDTH bits: signed multiplier.
REQ-007 SHALL have ports CargaA, DesplazaA, ResetA, CargaQ, DesplazaQ, CargaM, Resta and Fin, each input, 1 bit, driven by the control unit.
REQ-008 SHALL have port q0, output, 1 bit: Q[0], returned to the control unit.
REQ-009 SHALL have port q_1, output, 1 bit: the Booth guard bit, returned to the control unit.
REQ-010 SHALL have port Producto, output, 2*WIDTH bits: signed product.
REQ-011 SHALL have port Valido, output, 1 bit: product-valid indication.

Function
REQ-012 SHALL hold registers M (WIDTH), A (WIDTH+1, sign-extended accumulator), Q (WIDTH) and q_1 (1).
REQ-013 SHALL load M from Multiplicando on a clock edge with CargaM=1, and hold M otherwise.
REQ-014 SHALL set A, in priority order: ResetA -> 0; else CargaA -> A-sext(M) if Resta=1, else A+sext(M), modulo 2^(WIDTH+1); else DesplazaA -> arithmetic right shift, A[WIDTH] kept; else hold.
REQ-015 SHALL set Q, in priority order: CargaQ -> Multiplicador; else DesplazaQ -> {old A[0], Q[WIDTH-1:1]}; else hold.
REQ-016 SHALL clear q_1 to 0 with CargaQ=1, take old Q[0] with DesplazaQ=1 (and CargaQ=0), and hold otherwise.
REQ-017 SHALL compute all shifts from pre-edge register values, so DesplazaA+DesplazaQ together form a single arithmetic right shift of {A,Q,q_1}.
REQ-018 SHALL form the raw product as bits [2*WIDTH-1:0] of {A,Q}; the extra A bit makes Multiplicando=-2^(WIDTH-1) exact.
REQ-019 SHALL drive q0=Q[0] and q_1 directly from registers, with no combinational path from control inputs.
REQ-020 SHALL ignore Resta when CargaA=0.
REQ-021 SHALL treat CargaA together with DesplazaA per REQ-014 priority (load wins), although the control unit never issues it.

Reset
REQ-022 SHALL, on rst_n low, immediately clear M, A, Q, q_1, Producto, Valido and the Fin edge register to 0, independent of clk.
REQ-023 SHALL, on rst_n low mid-operation, abandon the operation and not raise Valido until a new Fin rising edge.
REQ-024 SHALL begin normal operation on the first clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL use macro RESULT_REG_EN.
REQ-026 SHALL, with RESULT_REG_EN defined, register Fin into fin_d, load Producto from the raw product on the edge where Fin=1 and fin_d=0, pulse Valido high for exactly one cycle on the following cycle, and otherwise hold Producto.
REQ-027 SHALL capture once per Fin rising edge even while Fin stays high, and SHALL capture on the first edge after reset if Fin is already high.
REQ-028 SHALL, without RESULT_REG_EN, drive Producto combinationally from the raw product and set Valido=Fin, with no fin_d register.

Verification
REQ-029 Scenario: M=0011 (3), Q=1110 (-2), full control sequence -> Producto=8'hFA, one Valido pulse.
REQ-030 Scenario: 7 x 7 -> Producto=8'h31; q0/q_1 after each shift follow the multiplier bits 1,1,1,0 / 0,1,1,1.
REQ-031 Scenario: -8 x -8 (1000 x 1000) -> Producto=8'h40, which proves the WIDTH+1 accumulator.
REQ-032 Scenario: -8 x 7 -> Producto=8'hC8; Fin held high for 10 extra cycles -> exactly one Valido pulse and Producto stable (with RESULT_REG_EN).
REQ-033 Scenario: rst_n pulsed low mid-way through the second iteration -> all registers 0 asynchronously, no Valido; then restart with 2 x 3 -> 8'h06.
REQ-034 Scenario: ResetA and CargaA asserted together, and CargaQ and DesplazaQ asserted together -> A=0, Q=Multiplicador, q_1=0.
